// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential unsigned shift-and-add multiplier.
//               Multiplies a WIDTH-bit multiplicand (inA) by a WIDTH-bit
//               multiplier (inB) into a 2*WIDTH-bit product over many cycles
//               using a start/done handshake and one five-state FSM.
//               Optional feature macro: SHIFT_ADD_MULT_EARLY_EXIT_EN
//                 defined   -> TEST ends the operation as soon as the
//                              remaining multiplier bits are all zero
//                 undefined -> always WIDTH shift steps (fixed latency
//                              2*WIDTH + popcount(inB))
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult #(
  parameter int WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy,
  output logic [2:0]           state,
  output logic [7:0]           count
);

  // FSM state encoding (codes 5..7 are illegal and recover to IDLE)
  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_TEST  = 3'd1;
  localparam logic [2:0] c_ADD   = 3'd2;
  localparam logic [2:0] c_SHIFT = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  // Pre-increment count value on the final SHIFT step
  localparam logic [7:0] c_LAST_CNT = 8'(WIDTH - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [2*WIDTH-1:0] r_m;        // multiplicand, shifted left each step
  logic [WIDTH-1:0]   r_q;        // multiplier, shifted right each step
  logic [2*WIDTH-1:0] r_product;  // running accumulator
  logic [7:0]         r_count;    // SHIFT steps completed
  logic               w_start_ok; // start is honoured only in IDLE/DONE

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
  logic               w_q_zero;
  assign w_q_zero = (r_q == '0);
`else
  logic               w_last_shift;
  assign w_last_shift = (r_count == c_LAST_CNT);
`endif

  assign w_start_ok = start && ((r_state == c_IDLE) || (r_state == c_DONE));

  // Next-state decode for the multiplier sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_next_state = c_TEST;
        end
      end
      c_TEST: begin
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        // No multiplier bits left: the accumulator is already final.
        if (w_q_zero) begin
          w_next_state = c_DONE;
        end else if (r_q[0]) begin
          w_next_state = c_ADD;
        end else begin
          w_next_state = c_SHIFT;
        end
`else
        if (r_q[0]) begin
          w_next_state = c_ADD;
        end else begin
          w_next_state = c_SHIFT;
        end
`endif
      end
      c_ADD: begin
        w_next_state = c_SHIFT;
      end
      c_SHIFT: begin
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        // Q is all zeros after WIDTH shifts, so TEST always terminates;
        // this keeps termination in a single place.
        w_next_state = c_TEST;
`else
        if (w_last_shift) begin
          w_next_state = c_DONE;
        end else begin
          w_next_state = c_TEST;
        end
`endif
      end
      c_DONE: begin
        if (start) begin
          w_next_state = c_TEST;
        end
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // State register and shift/add datapath; reset aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_product <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start_ok) begin
        r_m       <= {{WIDTH{1'b0}}, inA};
        r_q       <= inB;
        r_product <= '0;
        r_count   <= '0;
      end else if (r_state == c_ADD) begin
        // M never exceeds inA << (WIDTH-1), so the sum fits 2*WIDTH bits.
        r_product <= r_product + r_m;
      end else if (r_state == c_SHIFT) begin
        r_m     <= r_m << 1;
        r_q     <= r_q >> 1;
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign product = r_product;
  assign state   = r_state;
  assign count   = r_count;
  assign done    = (r_state == c_DONE);
  assign busy    = (r_state == c_TEST) || (r_state == c_ADD) ||
                   (r_state == c_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Self-checking bench for shift_add_mult (WIDTH=25) with
//               directed vectors and a random operand sweep. Expected
//               latency/count follow SHIFT_ADD_MULT_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

  localparam int WIDTH   = 25;
  localparam int LAT_MAX = 400;
  localparam int N_RAND  = 800;

  logic               clk;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   inA;
  logic [WIDTH-1:0]   inB;
  logic [2*WIDTH-1:0] product;
  logic               done;
  logic               busy;
  logic [2:0]         state;
  logic [7:0]         count;

  int n_checks;
  int n_fail;

  shift_add_mult #(.WIDTH(WIDTH)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .inA     (inA),
    .inB     (inB),
    .product (product),
    .done    (done),
    .busy    (busy),
    .state   (state),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int popcnt(input logic [WIDTH-1:0] v);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int msb_idx(input logic [WIDTH-1:0] v);
    int m = -1;
    for (int i = 0; i < WIDTH; i++) if (v[i]) m = i;
    return m;
  endfunction

  // Expected accept-to-done latency in edges for the current build
  function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    if (b == '0) return 1;
    return 2 * (msb_idx(b) + 1) + popcnt(b) + 1;
`else
    return 2 * WIDTH + popcnt(b);
`endif
  endfunction

  // Expected final count for the current build
  function automatic int exp_cnt(input logic [WIDTH-1:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    return msb_idx(b) + 1;
`else
    return WIDTH;
`endif
  endfunction

  // Issue one operation and measure edges from accept until done
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int lat);
    @(negedge clk);
    start = 1'b1;
    inA   = a;
    inB   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < LAT_MAX) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("op_done", 64'(done), 64'd1);
  endtask

  initial begin
    int          lat;
    logic [24:0] ra;
    logic [24:0] rb;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    start = 1'b0;
    inA   = '0;
    inB   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state",   64'(state),   64'd0);
    check_eq("rst_product", 64'(product), 64'd0);
    check_eq("rst_count",   64'(count),   64'd0);
    check_eq("rst_done",    64'(done),    64'd0);
    check_eq("rst_busy",    64'(busy),    64'd0);
    reset = 1'b0;

    // 3*5: default 52 cycles, count 25; early exit 2*3+2+1=9, count 3
    run_op(25'd3, 25'd5, lat);
    check_eq("p3x5",   64'(product), 64'd15);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    check_eq("lat3x5", 64'(lat),   64'd9);
    check_eq("cnt3x5", 64'(count), 64'd3);
`else
    check_eq("lat3x5", 64'(lat),   64'd52);
    check_eq("cnt3x5", 64'(count), 64'd25);
`endif
    check_eq("busy3x5", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("hold_done", 64'(done),    64'd1);
    check_eq("hold_prod", 64'(product), 64'd15);

    // All ones: (2^25-1)^2 = 2^50 - 2^26 + 1
    run_op(25'h1FFFFFF, 25'h1FFFFFF, lat);
    check_eq("pmax", 64'(product), 64'h3FFFFFC000001);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    check_eq("latmax", 64'(lat), 64'd76);
`else
    check_eq("latmax", 64'(lat), 64'd75);
`endif

    // Zero multiplier
    run_op(25'd12345, 25'd0, lat);
    check_eq("pzero", 64'(product), 64'd0);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    check_eq("latzero", 64'(lat),   64'd1);
    check_eq("cntzero", 64'(count), 64'd0);
`else
    check_eq("latzero", 64'(lat),   64'd50);
    check_eq("cntzero", 64'(count), 64'd25);
`endif

    // start pulsed mid-operation must be ignored (1000 = popcount 6, msb 9)
    @(negedge clk);
    start = 1'b1;
    inA   = 25'd1000;
    inB   = 25'd1000;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < LAT_MAX) begin
      if (lat == 9) begin
        start = 1'b1;
        inA   = 25'd55;
        inB   = 25'd66;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check_eq("ign_done", 64'(done),    64'd1);
    check_eq("ign_prod", 64'(product), 64'd1000000);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    check_eq("ign_lat", 64'(lat), 64'd27);
`else
    check_eq("ign_lat", 64'(lat), 64'd56);
`endif

    // Restart straight from DONE (6 = popcount 2, msb 2)
    run_op(25'd7, 25'd6, lat);
    check_eq("p7x6", 64'(product), 64'd42);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    check_eq("lat7x6", 64'(lat), 64'd9);
`else
    check_eq("lat7x6", 64'(lat), 64'd52);
`endif

    // Reset 20 cycles into a long operation
    @(negedge clk);
    start = 1'b1;
    inA   = 25'h1FFFFFF;
    inB   = 25'h1FFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("abort_state",   64'(state),   64'd0);
    check_eq("abort_product", 64'(product), 64'd0);
    check_eq("abort_count",   64'(count),   64'd0);
    check_eq("abort_done",    64'(done),    64'd0);

    // 100 = popcount 3, msb 6
    run_op(25'd100, 25'd100, lat);
    check_eq("p100", 64'(product), 64'd10000);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    check_eq("lat100", 64'(lat), 64'd18);
`else
    check_eq("lat100", 64'(lat), 64'd53);
`endif

    // Random sweep against inA*inB and the latency formula
    for (int i = 0; i < N_RAND; i++) begin
      ra = 25'($urandom);
      rb = (i % 50 == 7) ? 25'd0 : 25'($urandom);
      if (i % 10 == 3) rb = 25'($urandom_range(0, 255));
      run_op(ra, rb, lat);
      check_eq("rnd_prod", 64'(product), 64'(ra) * 64'(rb));
      check_eq("rnd_lat",  64'(lat),     64'(exp_lat(rb)));
      check_eq("rnd_cnt",  64'(count),   64'(exp_cnt(rb)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
